// File: rtl/instruction_count_reader.sv
// instruction_count_reader: dumps the per-opcode count table over valid/ready.
// Walks every opcode address in order and can zero each entry once it is delivered.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   start               one-cycle dump request, honoured only when idle
//   busy, done          dump in progress / one-cycle completion pulse
//   mem_address         address to the count memory port
//   mem_readData        synchronous read data (one cycle after the address)
//   mem_writeEnable     clear-write strobe (high only in the handshake cycle)
//   mem_writeData       always zero
//   out_valid/out_ready stream handshake
//   out_icode/out_count opcode and its count
//   out_last            marks the entry for the all-ones opcode
module instruction_count_reader #(
  parameter int ICODESIZE     = 4,
  parameter int COUNTBITS     = 4,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [ICODESIZE-1:0] mem_address,
  input  logic [COUNTBITS-1:0] mem_readData,
  output logic                 mem_writeEnable,
  output logic [COUNTBITS-1:0] mem_writeData,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ICODESIZE-1:0] out_icode,
  output logic [COUNTBITS-1:0] out_count,
  output logic                 out_last
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    SEND,
    FIN
  } state_t;

  localparam logic [ICODESIZE-1:0] LAST_ADDR = '1;
  localparam logic [ICODESIZE-1:0] ONE       = 1;

  state_t state;
  logic   hs;

  assign hs = out_valid & out_ready;

  // The clear has to land in the handshake cycle itself, so the strobe
  // follows out_ready directly. mem_address already equals out_icode
  // throughout SEND, which makes it the clear address too.
  assign mem_writeEnable = CLEAR_ON_READ & hs;
  assign mem_writeData   = '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_address <= '0;
      out_valid   <= 1'b0;
      out_icode   <= '0;
      out_count   <= '0;
      out_last    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= READ;
            busy        <= 1'b1;
            mem_address <= '0;
          end
        end
        READ: begin
          state <= WAIT;
        end
        WAIT: begin
          out_count <= mem_readData;
          out_icode <= mem_address;
          out_last  <= (mem_address == LAST_ADDR);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              mem_address <= mem_address + ONE;
              state       <= READ;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_count_reader.sv
// tb_instruction_count_reader: directed bench for the count-table readout.
// Main instance 16x4 with clearing; small instance 4x4 without clearing.
module tb_instruction_count_reader;

  logic       clock;
  logic       reset;

  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] addr;
  logic [3:0] rdata;
  logic       we;
  logic [3:0] wdata;
  logic       valid;
  logic       ready;
  logic [3:0] icode;
  logic [3:0] count;
  logic       last;

  logic       s_start;
  logic       s_busy;
  logic       s_done;
  logic [1:0] s_addr;
  logic [3:0] s_rdata;
  logic       s_we;
  logic [3:0] s_wdata;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_icode;
  logic [3:0] s_count;
  logic       s_last;

  logic [3:0] mem [16];
  logic       pre;
  logic [3:0] s_mem [4];
  logic       s_pre;
  int         exp_cnt [16];

  int n_cmp;
  int n_bad;

  instruction_count_reader #(
    .ICODESIZE(4), .COUNTBITS(4), .CLEAR_ON_READ(1'b1)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .busy(busy), .done(done),
    .mem_address(addr), .mem_readData(rdata),
    .mem_writeEnable(we), .mem_writeData(wdata),
    .out_valid(valid), .out_ready(ready),
    .out_icode(icode), .out_count(count), .out_last(last)
  );

  instruction_count_reader #(
    .ICODESIZE(2), .COUNTBITS(4), .CLEAR_ON_READ(1'b0)
  ) sdut (
    .clock(clock), .reset(reset), .start(s_start),
    .busy(s_busy), .done(s_done),
    .mem_address(s_addr), .mem_readData(s_rdata),
    .mem_writeEnable(s_we), .mem_writeData(s_wdata),
    .out_valid(s_valid), .out_ready(s_ready),
    .out_icode(s_icode), .out_count(s_count), .out_last(s_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pre) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'(i);
    end else if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

  always @(posedge clock) begin
    if (s_pre) begin
      for (int i = 0; i < 4; i++) s_mem[i] <= 4'(12 - i);
    end else if (s_we) begin
      s_mem[s_addr] <= s_wdata;
    end
    s_rdata <= s_mem[s_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload();
    pre = 1'b1;
    tick();
    pre = 1'b0;
    for (int i = 0; i < 16; i++) exp_cnt[i] = i;
  endtask

  task automatic check_mem();
    for (int i = 0; i < 16; i++) chk($sformatf("mem%0d", i), mem[i], exp_cnt[i]);
  endtask

  // Start in cycle 0, then follow the dump cycle by cycle.
  // stall: cycles out_ready stays low at the start of each entry.
  task automatic dump(input int stall, input int restart_at, input int reset_at);
    int n, ndone, fin, sc, hs_cyc;
    logic [3:0] pi, pc;
    logic stalled;
    n = 0; ndone = 0; fin = -1; sc = 0; stalled = 1'b0;
    pi = '0; pc = '0;
    start = 1'b1;
    for (int cyc = 1; cyc < 400; cyc++) begin
      @(posedge clock);
      #1;
      start = (cyc == restart_at);
      ready = !(valid && sc < stall);
      if (!ready) sc++;
      #1;
      if (cyc == reset_at) begin
        #2;
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_last", last, 0);
        chk("rst_icode", icode, 0);
        chk("rst_count", count, 0);
        chk("rst_addr", addr, 0);
        chk("rst_we", we, 0);
        return;
      end
      if (cyc == 1) chk("addr_c1", addr, 0);
      if (stalled) begin
        chk("stall_valid", valid, 1);
        chk("stall_icode", icode, pi);
        chk("stall_count", count, pc);
      end
      if (valid && ready) begin
        hs_cyc = 3 + (3 + stall) * n + stall;
        chk("hs_icode", icode, n);
        chk("hs_count", count, exp_cnt[n]);
        chk("hs_last", last, (n == 15));
        chk("hs_addr", addr, n);
        chk("hs_we", we, 1);
        chk("hs_cycle", cyc, hs_cyc);
        exp_cnt[n] = 0;
        n++;
        sc = 0;
      end else begin
        chk("idle_we", we, 0);
      end
      stalled = valid && !ready;
      pi = icode;
      pc = count;
      if (done) begin
        ndone++;
        if (fin < 0) begin
          fin = cyc;
          chk("done_cycle", cyc, 3 + (3 + stall) * 15 + stall + 1);
        end
      end
      chk("busy", busy, (fin < 0));
      if (fin >= 0 && cyc == fin + 3) break;
    end
    chk("entries", n, 16);
    chk("done_pulses", ndone, 1);
    ready = 1'b0;
  endtask

  task automatic sdump();
    int n, ndone, fin;
    n = 0; ndone = 0; fin = -1;
    s_start = 1'b1;
    s_ready = 1'b1;
    for (int cyc = 1; cyc < 100; cyc++) begin
      tick();
      s_start = 1'b0;
      #1;
      chk("s_we", s_we, 0);
      if (s_valid && s_ready) begin
        chk("s_icode", s_icode, n);
        chk("s_count", s_count, 12 - n);
        chk("s_last", s_last, (n == 3));
        chk("s_hs_cycle", cyc, 3 + 3 * n);
        n++;
      end
      if (s_done) begin
        ndone++;
        if (fin < 0) begin
          fin = cyc;
          chk("s_done_cycle", cyc, 13);
        end
      end
      if (fin >= 0 && cyc == fin + 3) break;
    end
    chk("s_entries", n, 4);
    chk("s_done_pulses", ndone, 1);
    for (int i = 0; i < 4; i++) chk($sformatf("s_mem%0d", i), s_mem[i], 12 - i);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; start = 1'b0; ready = 1'b0; pre = 1'b0;
    s_start = 1'b0; s_ready = 1'b0; s_pre = 1'b0;
    tick();
    tick();
    chk("r_busy", busy, 0);
    chk("r_done", done, 0);
    chk("r_valid", valid, 0);
    chk("r_last", last, 0);
    chk("r_icode", icode, 0);
    chk("r_count", count, 0);
    chk("r_addr", addr, 0);
    chk("r_we", we, 0);
    chk("r_wdata", wdata, 0);
    chk("r_s_valid", s_valid, 0);
    reset = 1'b1;
    tick();

    preload();
    dump(0, -1, -1);
    check_mem();

    preload();
    dump(2, -1, -1);
    check_mem();

    preload();
    dump(0, 10, -1);
    check_mem();

    preload();
    dump(0, -1, 20);
    tick();
    reset = 1'b1;
    tick();
    check_mem();
    chk("mem6_kept", mem[6], 6);
    dump(0, -1, -1);
    check_mem();

    s_pre = 1'b1;
    tick();
    s_pre = 1'b0;
    sdump();
    sdump();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
